// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR pattern state type, defaults and feedback helper
package lfsr_pkg;

   typedef enum logic [1:0] {SEED, CHECK, LOCKED} lfsr_state_e;

   localparam int LFSR_WIDTH = 4;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 4'b0011;

   // Shared with the generator so both ends agree on the polynomial.
   function automatic logic lfsr_fb(input logic [31:0] win, input logic [31:0] taps);
      return ^(win & taps);
   endfunction

endpackage

// File: rtl/lfsr_chk_cnt.sv
// rtl/lfsr_chk_cnt.sv - saturating counter with increment and clear
module lfsr_chk_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR pattern checker with lock and error count
// Optional bit_count output enabled by LFSR_CHK_BITCNT_EN.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int               WIDTH    = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS),
   parameter int               LOCK_CNT = 8,
   parameter int               LOSS_CNT = 3,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITCNT_EN
   ,
   output logic [31:0]      bit_count
`endif
);

   localparam int FILL_W  = $clog2(WIDTH + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(LOSS_CNT + 1);

   lfsr_state_e        state;
   logic [WIDTH-1:0]   win;
   logic [WIDTH-1:0]   win_next;
   logic [FILL_W-1:0]  fill;
   logic [MATCH_W-1:0] match;
   logic [MISS_W-1:0]  miss;
   logic               exp_bit;
   logic               mismatch;
   logic               err_inc;
   logic               lose_lock;

   // win[0] is the oldest bit; the expected bit comes from the window before the shift.
   assign win_next  = {in_bit, win[WIDTH-1:1]};
   assign exp_bit   = lfsr_fb(32'(win), 32'(TAPS));
   assign mismatch  = in_bit ^ exp_bit;
   assign err_inc   = in_valid && (state == LOCKED) && mismatch;
   assign lose_lock = err_inc && (miss == MISS_W'(LOSS_CNT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEED;
         win       <= '0;
         fill      <= '0;
         match     <= '0;
         miss      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= err_inc;
         if (in_valid) begin
            win <= win_next;
            case (state)
               SEED: begin
                  if (fill == FILL_W'(WIDTH - 1)) begin
                     fill <= '0;
                     // An all-zero window is the lock-up pattern; keep refilling.
                     if (win_next != '0) begin
                        state <= CHECK;
                        match <= '0;
                     end
                  end else begin
                     fill <= fill + FILL_W'(1);
                  end
               end
               CHECK: begin
                  if (mismatch) begin
                     state <= SEED;
                     fill  <= '0;
                  end else begin
                     match <= match + MATCH_W'(1);
                     if (match == MATCH_W'(LOCK_CNT - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        miss   <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (lose_lock) begin
                     state  <= SEED;
                     locked <= 1'b0;
                     fill   <= '0;
                     miss   <= '0;
                  end else if (mismatch) begin
                     miss <= miss + MISS_W'(1);
                  end else begin
                     miss <= '0;
                  end
               end
               default: begin
                  state  <= SEED;
                  locked <= 1'b0;
                  fill   <= '0;
               end
            endcase
         end
      end
   end

   lfsr_chk_cnt #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (err_inc),
      .count (err_count)
   );

`ifdef LFSR_CHK_BITCNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_count <= '0;
      end else if (in_valid && (state == LOCKED)) begin
         bit_count <= lose_lock ? 32'd0 : bit_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed scoreboard bench for lfsr_checker
module tb_lfsr_checker;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_bit;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
`ifdef LFSR_CHK_BITCNT_EN
   logic [31:0] bit_count;
`endif

   typedef struct {
      logic        lk;
      logic        ep;
      logic [15:0] ec;
      string       tag;
   } exp_t;

   exp_t       sb[$];
   int         total;
   int         failed;
   logic [3:0] gq;

   lfsr_checker dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
`ifdef LFSR_CHK_BITCNT_EN
      ,
      .bit_count (bit_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic el, input logic ep,
                        input int ec, input string tag);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      in_bit   = b;
      e.lk  = el;
      e.ep  = ep;
      e.ec  = 16'(ec);
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".locked"}, 32'(locked), 32'(e.lk));
      check({e.tag, ".err_pulse"}, 32'(err_pulse), 32'(e.ep));
      check({e.tag, ".err_count"}, 32'(err_count), 32'(e.ec));
   endtask

   task automatic gen_drive(input logic v, input logic inv, input logic el, input logic ep,
                            input int ec, input string tag);
      logic b;
      b = 1'b0;
      if (v) begin
         b  = gq[0] ^ inv;
         gq = {gq[1] ^ gq[0], gq[3:1]};
      end
      drive(v, b, el, ep, ec, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".locked"}, 32'(locked), 32'd0);
      check({tag, ".err_pulse"}, 32'(err_pulse), 32'd0);
      check({tag, ".err_count"}, 32'(err_count), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
      check({tag, ".bit_count"}, bit_count, 32'd0);
`endif
      reset    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      gq       = 4'b0001;
   endtask

   initial begin
      total    = 0;
      failed   = 0;
      gq       = 4'b0001;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("por.locked", 32'(locked), 32'd0);
      check("por.err_pulse", 32'(err_pulse), 32'd0);
      check("por.err_count", 32'(err_count), 32'd0);
      reset = 1'b0;

      // Clean lock and 100 error-free bits
      for (int i = 1; i <= 100; i++) gen_drive(1'b1, 1'b0, i >= 12, 1'b0, 0, "t1_clean");
`ifdef LFSR_CHK_BITCNT_EN
      check("t1.bit_count", bit_count, 32'd88);
`endif

      // Single bad bit; it re-enters the feedback taps three and four bits later
      gen_drive(1'b1, 1'b1, 1'b1, 1'b1, 1, "t2_bad");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b0, 1, "t2_after1");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b0, 1, "t2_after2");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b1, 2, "t2_echo1");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b1, 3, "t2_echo2");
      for (int i = 0; i < 5; i++) gen_drive(1'b1, 1'b0, 1'b1, 1'b0, 3, "t2_tail");

      // Loss of lock and relock
      do_reset("t3_rst");
      for (int i = 1; i <= 20; i++) gen_drive(1'b1, 1'b0, i >= 12, 1'b0, 0, "t3_lock");
      gen_drive(1'b1, 1'b1, 1'b1, 1'b1, 1, "t3_bad1");
      gen_drive(1'b1, 1'b1, 1'b1, 1'b1, 2, "t3_bad2");
      gen_drive(1'b1, 1'b1, 1'b0, 1'b1, 3, "t3_bad3");
`ifdef LFSR_CHK_BITCNT_EN
      check("t3.bit_count_loss", bit_count, 32'd0);
`endif
      for (int i = 1; i <= 16; i++) gen_drive(1'b1, 1'b0, i >= 12, 1'b0, 3, "t3_relock");
`ifdef LFSR_CHK_BITCNT_EN
      check("t3.bit_count_relock", bit_count, 32'd4);
`endif

      // Zero stream and idle cycles never leave SEED
      do_reset("t4_rst");
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, "t4_zero");
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, "t4_idle");

      // Gapped valid: lock counts valid bits only
      do_reset("t5_rst");
      for (int k = 1; k <= 30; k++) begin
         gen_drive(1'b1, 1'b0, k >= 12, 1'b0, 0, "t5_valid");
         gen_drive(1'b0, 1'b0, k >= 12, 1'b0, 0, "t5_gap");
      end

      // Reset while locked with two counted errors
      do_reset("t6_rst0");
      for (int i = 1; i <= 15; i++) gen_drive(1'b1, 1'b0, i >= 12, 1'b0, 0, "t6_lock");
      gen_drive(1'b1, 1'b1, 1'b1, 1'b1, 1, "t6_bad");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b0, 1, "t6_after1");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b0, 1, "t6_after2");
      gen_drive(1'b1, 1'b0, 1'b1, 1'b1, 2, "t6_echo1");
      do_reset("t6_rst");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, "t6_post");
      for (int i = 1; i <= 13; i++) gen_drive(1'b1, 1'b0, i >= 12, 1'b0, 0, "t6_relock");

      $display("%0d/%0d checks passed", total - failed, total);
      $finish;
   end

endmodule
